// File: rtl/operand_monitor_if.sv
// rtl/operand_monitor_if.sv - cpu-side inputs and light_show-side outputs of operand_monitor
interface operand_monitor_if #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4,
   parameter int IDX_W  = 2,
   parameter int IR_W   = 8
);
   logic                   irload;
   logic [IR_W-1:0]        irout;
   logic [NREG*DATA_W-1:0] regs_flat;
   logic                   scan_en;
   logic [DATA_W-1:0]      rd;
   logic [DATA_W-1:0]      rs;
   logic                   rd_valid;
   logic                   rs_valid;
   logic [IDX_W-1:0]       scan_idx;
   logic                   rd_changed;

   modport master (
      output irload, irout, regs_flat, scan_en,
      input  rd, rs, rd_valid, rs_valid, scan_idx, rd_changed
   );

   modport slave (
      input  irload, irout, regs_flat, scan_en,
      output rd, rs, rd_valid, rs_valid, scan_idx, rd_changed
   );
endinterface

// File: rtl/operand_monitor.sv
// rtl/operand_monitor.sv - decodes IR rd/rs fields and presents registered operand values, with auto-scan
module operand_monitor #(
   parameter int          DATA_W   = 8,
   parameter int          NREG     = 4,
   parameter int          IDX_W    = 2,
   parameter int          IR_W     = 8,
   parameter logic [15:0] RD_MASK  = 16'h03FE,
   parameter logic [15:0] RS_MASK  = 16'h03FE,
   parameter int          SCAN_DIV = 3
) (
   input logic             clk,
   input logic             rst,
   operand_monitor_if.slave bus
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, TRACK} state_t;

   state_t            state;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  rs_idx;
   logic              rd_vld;
   logic              rs_vld;
   logic [DATA_W-1:0] snapshot;
   logic [DIV_W-1:0]  div;
   logic [IDX_W-1:0]  scan_idx_q;
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] rs_q;
   logic              rd_valid_q;
   logic              rs_valid_q;
   logic              rd_changed_q;

   logic [DATA_W-1:0] regs [NREG];
   logic [3:0]        ir_op;
   logic [IDX_W-1:0]  ir_rd;
   logic [IDX_W-1:0]  ir_rs;

   for (genvar i = 0; i < NREG; i++) begin : g_regs
      assign regs[i] = bus.regs_flat[i*DATA_W +: DATA_W];
   end

   assign ir_op = bus.irout[IR_W-1 -: 4];
   assign ir_rd = bus.irout[2*IDX_W-1:IDX_W];
   assign ir_rs = bus.irout[IDX_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         rd_idx       <= '0;
         rs_idx       <= '0;
         rd_vld       <= 1'b0;
         rs_vld       <= 1'b0;
         snapshot     <= '0;
         div          <= '0;
         scan_idx_q   <= '0;
         rd_q         <= '0;
         rs_q         <= '0;
         rd_valid_q   <= 1'b0;
         rs_valid_q   <= 1'b0;
         rd_changed_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.irload) state <= DECODE;
            end
            DECODE: begin
               // A further irload here keeps us decoding so the newest IR wins.
               rd_idx       <= ir_rd;
               rs_idx       <= ir_rs;
               rd_vld       <= RD_MASK[ir_op];
               rs_vld       <= RS_MASK[ir_op];
               snapshot     <= regs[ir_rd];
               rd_changed_q <= 1'b0;
               if (!bus.irload) state <= TRACK;
            end
            TRACK: begin
               if (rd_vld && (regs[rd_idx] != snapshot)) rd_changed_q <= 1'b1;
               if (bus.irload) state <= DECODE;
            end
            default: state <= IDLE;
         endcase

         // Scan only overrides what is shown; decode/track state keeps advancing underneath.
         if (bus.scan_en) begin
            if (div == DIV_W'(SCAN_DIV - 1)) begin
               div        <= '0;
               scan_idx_q <= scan_idx_q + 1'b1;
            end else begin
               div <= div + 1'b1;
            end
            rd_q       <= regs[scan_idx_q];
            rs_q       <= '0;
            rd_valid_q <= 1'b1;
            rs_valid_q <= 1'b0;
         end else begin
            rd_q       <= rd_vld ? regs[rd_idx] : '0;
            rs_q       <= rs_vld ? regs[rs_idx] : '0;
            rd_valid_q <= rd_vld;
            rs_valid_q <= rs_vld;
         end
      end
   end

   assign bus.rd         = rd_q;
   assign bus.rs         = rs_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rs_valid   = rs_valid_q;
   assign bus.scan_idx   = scan_idx_q;
   assign bus.rd_changed = rd_changed_q;
endmodule

// File: tb/tb_operand_monitor.sv
// tb/tb_operand_monitor.sv - scoreboard bench for operand_monitor
module tb_operand_monitor;
   typedef struct packed {
      logic [7:0] rd;
      logic [7:0] rs;
      logic       rdv;
      logic       rsv;
      logic [1:0] idx;
      logic       chg;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb [$];

   int   m_div = 0;
   int   m_idx = 0;

   operand_monitor_if #(.DATA_W(8), .NREG(4), .IDX_W(2), .IR_W(8)) bus ();

   operand_monitor #(
      .DATA_W(8), .NREG(4), .IDX_W(2), .IR_W(8),
      .RD_MASK(16'h03FE), .RS_MASK(16'h03FE), .SCAN_DIV(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t obs();
      return '{bus.rd, bus.rs, bus.rd_valid, bus.rs_valid, bus.scan_idx, bus.rd_changed};
   endfunction

   function automatic string fmt(exp_t e);
      return $sformatf("rd=%h rs=%h rdv=%b rsv=%b idx=%0d chg=%b", e.rd, e.rs, e.rdv, e.rsv, e.idx, e.chg);
   endfunction

   function automatic exp_t mk(logic [7:0] rd, logic [7:0] rs, logic rdv, logic rsv, int idx, logic chg);
      return '{rd, rs, rdv, rsv, idx[1:0], chg};
   endfunction

   function automatic logic [7:0] reg_val(int i);
      logic [31:0] r;
      r = bus.regs_flat;
      return r[i*8 +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scan_model_step();
      if (m_div == 2) begin
         m_div = 0;
         m_idx = (m_idx + 1) % 4;
      end else begin
         m_div = m_div + 1;
      end
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.irload    = 1'($urandom);
         bus.irout     = 8'($urandom);
         bus.regs_flat = $urandom;
         bus.scan_en   = 1'($urandom);
         sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
         end
      end
      bus.irload  = 1'b0;
      bus.scan_en = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset_release[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
         end
      end
   endtask

   task automatic test_decode();
      exp_t e;
      bus.regs_flat = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.irout  = 8'h16;
      bus.irload = 1'b1;
      sb.push_back(mk(8'h22, 8'h33, 1'b1, 1'b1, 0, 1'b0));
      tick();
      bus.irload = 1'b0;
      tick();
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL decode_16: got %s want %s", fmt(obs()), fmt(e));
      end
   endtask

   task automatic test_rd_changed();
      exp_t e;
      bus.regs_flat = {8'h44, 8'h33, 8'h55, 8'h11};
      sb.push_back(mk(8'h55, 8'h33, 1'b1, 1'b1, 0, 1'b1));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL rd_changed_set: got %s want %s", fmt(obs()), fmt(e));
      end
      bus.regs_flat = {8'h44, 8'h33, 8'h22, 8'h11};
      sb.push_back(mk(8'h22, 8'h33, 1'b1, 1'b1, 0, 1'b1));
      tick();
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL rd_changed_sticky: got %s want %s", fmt(obs()), fmt(e));
      end
   endtask

   task automatic test_masked_opcode();
      exp_t e;
      bus.irout  = 8'h05;
      bus.irload = 1'b1;
      sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0));
      tick();
      bus.irload = 1'b0;
      tick();
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL masked_op0: got %s want %s", fmt(obs()), fmt(e));
      end
   endtask

   task automatic test_scan();
      exp_t e;
      bus.scan_en = 1'b1;
      for (int k = 0; k < 15; k++) begin
         sb.push_back(mk(reg_val(m_idx), 8'h00, 1'b1, 1'b0, (m_div == 2) ? (m_idx + 1) % 4 : m_idx, 1'b0));
         scan_model_step();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL scan_step[%0d]: got %s want %s", k, fmt(obs()), fmt(e));
         end
      end
      bus.scan_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, m_idx, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL scan_off_hold[%0d]: got %s want %s", k, fmt(obs()), fmt(e));
         end
      end
      bus.scan_en = 1'b1;
      sb.push_back(mk(reg_val(m_idx), 8'h00, 1'b1, 1'b0, (m_div == 2) ? (m_idx + 1) % 4 : m_idx, 1'b0));
      scan_model_step();
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL scan_resume: got %s want %s", fmt(obs()), fmt(e));
      end
      bus.scan_en = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bus.irout  = 8'h16;
      bus.irload = 1'b1;
      tick();
      bus.irout  = 8'h2D;
      sb.push_back(mk(8'h44, 8'h22, 1'b1, 1'b1, m_idx, 1'b0));
      tick();
      bus.irload = 1'b0;
      tick();
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL back_to_back_2d: got %s want %s", fmt(obs()), fmt(e));
      end
   endtask

   task automatic test_reset_mid_scan();
      exp_t e;
      bus.scan_en = 1'b1;
      repeat (4) tick();
      sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0));
      #2;
      rst = 1'b0;
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_mid_scan: got %s want %s", fmt(obs()), fmt(e));
      end
      bus.scan_en = 1'b0;
      tick();
      rst = 1'b1;
      sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0));
      tick();
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL after_reset_idle: got %s want %s", fmt(obs()), fmt(e));
      end
   endtask

   initial begin
      bus.irload    = 1'b0;
      bus.irout     = '0;
      bus.regs_flat = '0;
      bus.scan_en   = 1'b0;
      test_reset();
      test_decode();
      test_rd_changed();
      test_masked_opcode();
      test_scan();
      test_back_to_back();
      test_reset_mid_scan();
      if (sb.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
